keypad_frontend: RTL

- Driving end of the digit-entry interface into the lock controller.
- Synchronises and debounces four raw active-low pushbuttons.
- Emits a clean active-low one-hot key bus: 4'b1111 means no key.
- Counts digits and generates timeout_error when entry stalls mid-sequence.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/keypad_frontend_if.sv | 37 +++
 rtl/key_debounce.sv | 56 +++++
 rtl/keypad_frontend.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad digit-entry front end.
//   key_t        4-bit active-low key bus type
//   KEY_NONE     no key pressed
//   KEY0..KEY3   the four legal one-hot (active-low) key codes
//   state_t      front-end FSM states
//   onehot_low() 1 when exactly one bit of a key word is low
package keypad_pkg;

  typedef logic [3:0] key_t;

  localparam key_t KEY_NONE = 4'b1111;
  localparam key_t KEY0     = 4'b1110;
  localparam key_t KEY1     = 4'b1101;
  localparam key_t KEY2     = 4'b1011;
  localparam key_t KEY3     = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_RELEASED,
    ST_LOCKOUT
  } state_t;

  function automatic logic onehot_low(input key_t k);
    return (k == KEY0) || (k == KEY1) || (k == KEY2) || (k == KEY3);
  endfunction

endpackage

// File: rtl/keypad_frontend_if.sv
// keypad_frontend_if: digit-entry bus from the keypad front end to the lock.
//   key           debounced active-low one-hot key, KEY_NONE when idle
//   key_event     one-cycle pulse when key leaves KEY_NONE
//   digit_count   digits accepted in the current sequence
//   timeout_error inter-digit timeout, held for a fixed number of cycles
//   multi_key     high while a multi-key press is being rejected
// master = keypad front end (driver), slave = lock controller (receiver).
interface keypad_frontend_if #(
  parameter int NUM_DIGITS = 4
);
  import keypad_pkg::*;

  localparam int DC_W = $clog2(NUM_DIGITS + 1);

  key_t            key;
  logic            key_event;
  logic [DC_W-1:0] digit_count;
  logic            timeout_error;
  logic            multi_key;

  modport master (
    output key,
    output key_event,
    output digit_count,
    output timeout_error,
    output multi_key
  );

  modport slave (
    input key,
    input key_event,
    input digit_count,
    input timeout_error,
    input multi_key
  );

endinterface

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser plus stability counter for a group of
// raw buttons.
//   clock      system clock
//   reset      asynchronous, active-high
//   raw_in     raw button levels, asynchronous to clock
//   sync_keys  synchronised levels
//   stable     high once sync_keys has held its value DEBOUNCE_CYCLES cycles
module key_debounce #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] sync_keys,
  output logic             stable
);

  localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // cnt_q is the number of cycles sync_keys has held its present value: it
  // restarts at 0 on the same edge sync_keys takes a new value, so the
  // raw-to-stable path is 2 synchroniser cycles plus DEBOUNCE_CYCLES.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    if (sync1_q != sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sync_keys = sync2_q;
  assign stable    = (cnt_q == CNT_MAX);

endmodule

// File: rtl/keypad_frontend.sv
// keypad_frontend: driving end of the digit-entry interface into the lock.
// Debounces four raw active-low buttons, accepts single-key presses, rejects
// multi-key presses, counts digits and flags a stalled sequence.
//   clock     system clock
//   reset     asynchronous, active-high
//   raw_keys  raw active-low buttons, asynchronous to clock
//   bus       keypad_frontend_if master: key, key_event, digit_count,
//             timeout_error, multi_key
module keypad_frontend
  import keypad_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 250000000,
  parameter int ERR_HOLD_CYCLES = 8
) (
  input  logic clock,
  input  logic reset,
  input  key_t raw_keys,
  keypad_frontend_if.master bus
);

  localparam int DC_W   = $clog2(NUM_DIGITS + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HOLD_W = $clog2(ERR_HOLD_CYCLES + 1);

  localparam logic [DC_W-1:0]   DIGIT_LAST = DC_W'(NUM_DIGITS);
  localparam logic [TMO_W-1:0]  TMO_MAX    = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(ERR_HOLD_CYCLES);

  key_t sync_keys;
  logic deb_stable;

  key_debounce #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .IDLE_LEVEL     (KEY_NONE)
  ) u_debounce (
    .clock    (clock),
    .reset    (reset),
    .raw_in   (raw_keys),
    .sync_keys(sync_keys),
    .stable   (deb_stable)
  );

  state_t            state_q, state_d;
  key_t              key_q, key_d;
  logic              key_event_q, key_event_d;
  logic [DC_W-1:0]   digit_q, digit_d;
  logic              armed_q, armed_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [DC_W-1:0]   digit_inc;
  logic              press_accept;
  logic              fire;

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    key_event_d  = 1'b0;
    digit_d      = digit_q;
    armed_d      = armed_q;
    tmo_d        = tmo_q;
    hold_d       = hold_q;
    digit_inc    = digit_q + DC_W'(1);
    press_accept = 1'b0;
    fire         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (deb_stable && onehot_low(sync_keys)) begin
          state_d      = ST_PRESSED;
          key_d        = sync_keys;
          key_event_d  = 1'b1;
          press_accept = 1'b1;
        end else if (deb_stable && (sync_keys != KEY_NONE)) begin
          state_d = ST_LOCKOUT;
        end
      end

      ST_PRESSED: begin
        if (deb_stable && (sync_keys == KEY_NONE)) begin
          state_d = ST_RELEASED;
          key_d   = KEY_NONE;
        end else if (deb_stable && (sync_keys != key_q)) begin
          // A second key joined or the key was swapped without a release.
          state_d = ST_LOCKOUT;
          key_d   = KEY_NONE;
        end
      end

      ST_RELEASED: begin
        state_d = ST_IDLE;
        if (digit_inc == DIGIT_LAST) begin
          digit_d = '0;
          armed_d = 1'b0;
        end else begin
          digit_d = digit_inc;
          armed_d = 1'b1;
          // The release cycle itself is the first idle cycle of the gap.
          tmo_d   = TMO_W'(1);
        end
      end

      ST_LOCKOUT: begin
        if (deb_stable && (sync_keys == KEY_NONE)) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A press accepted on the same cycle the timeout would fire wins.
    if (press_accept) begin
      tmo_d = '0;
    end else if (armed_q && (state_q == ST_IDLE)) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d   = TMO_MAX;
        armed_d = 1'b0;
        digit_d = '0;
        fire    = 1'b1;
      end else if (tmo_q != TMO_MAX) begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    if (fire) begin
      hold_d = HOLD_MAX;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      key_q       <= KEY_NONE;
      key_event_q <= 1'b0;
      digit_q     <= '0;
      armed_q     <= 1'b0;
      tmo_q       <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      key_event_q <= key_event_d;
      digit_q     <= digit_d;
      armed_q     <= armed_d;
      tmo_q       <= tmo_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.key           = key_q;
  assign bus.key_event     = key_event_q;
  assign bus.digit_count   = digit_q;
  assign bus.timeout_error = (hold_q != '0);
  assign bus.multi_key     = (state_q == ST_LOCKOUT);

endmodule
